// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider with div-by-zero fast path and synchronous flush.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH+1:0] shifted, trial;
  logic             trial_ok;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] a_mag, b_mag, q_fin, r_fin;
  logic             last_iter;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_out = 1'b0;
    valid_out = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        ready_out = 1'b1;
        busy      = 1'b0;
        if (valid_in) state_nxt = LOAD;
      end
      LOAD:    state_nxt = (op_b == '0) ? DONE : RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE: begin
        valid_out = 1'b1;
        if (ready_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign last_iter = (cnt == CNT_LAST);

  // ---------------- iteration step ----------------
  // rem never exceeds the divisor, so its top bit is zero and the widened
  // subtraction's MSB is a clean borrow.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {2'b00, dvs};
    trial_ok = ~trial[WIDTH+1];
    rem_nxt  = trial_ok ? trial[WIDTH:0] : shifted[WIDTH:0];
    quo_nxt  = {quo[WIDTH-2:0], trial_ok};
  end

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  // MIN/-1 needs no special case: |MIN| divides to the MIN bit pattern and
  // the two negative signs cancel.
  assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
  assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;
  assign q_fin = neg_q ? -quo_nxt : quo_nxt;
  assign r_fin = neg_r ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (!flush && state == LOAD) begin
      neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
      neg_r <= op_a[WIDTH-1];
    end
  end
`else
  assign a_mag = op_a;
  assign b_mag = op_b;
  assign q_fin = quo_nxt;
  assign r_fin = rem_nxt[WIDTH-1:0];
`endif

  // ---------------- datapath ----------------
  // A flush freezes every datapath register; only the state returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a        <= '0;
      op_b        <= '0;
      dvs         <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            op_a <= dividend;
            op_b <= divisor;
          end
        end
        LOAD: begin
          if (op_b == '0) begin
            quotient    <= '1;
            remainder   <= op_a;
            div_by_zero <= 1'b1;
          end else begin
            rem <= '0;
            quo <= a_mag;
            dvs <= b_mag;
            cnt <= '0;
          end
        end
        RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            quotient    <= q_fin;
            remainder   <= r_fin;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Bench for div_iter_unit at WIDTH=8: directed table, corner sequences and random ops
// against an arithmetic reference model (signed model when DIV_SIGNED_EN is defined).
module tb_div_iter_unit;
  localparam int W = 8;

  logic         clk, rst_n, flush, valid_in, ready_in;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         ready_out, valid_out, div_by_zero, busy;

  int checks = 0;
  int errors = 0;

  div_iter_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .valid_in(valid_in), .ready_out(ready_out),
    .dividend(dividend), .divisor(divisor),
    .valid_out(valid_out), .ready_in(ready_in),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         z;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic from the divider's rules.
  task automatic model(input logic [W-1:0] a, b, output logic [W-1:0] q, r, output logic z);
`ifdef DIV_SIGNED_EN
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (sa == -(1 << (W-1)) && sb == -1) begin
      q = a; r = '0; z = 1'b0;
    end else begin
      q = W'(sa / sb); r = W'(sa % sb); z = 1'b0;
    end
`else
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
`endif
  endtask

  // Latency is counted in cycles including the handshake cycle, so a result
  // visible right after the first edge past the handshake counts as 2.
  task automatic run_op(input logic [W-1:0] a, b, input int stall,
                        input logic [W-1:0] eq, er, input logic ez, input int elat,
                        input string tag);
    int n, lat;
    n = 0;
    while (ready_out !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_ready_before"}, ready_out, 1);
    dividend = a; divisor = b; valid_in = 1'b1; ready_in = (stall == 0);
    @(negedge clk);
    valid_in = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    lat = 1;
    while (valid_out !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, valid_out, 1);
      chk({tag, "_hold_q"}, quotient, eq);
      chk({tag, "_hold_r"}, remainder, er);
      chk({tag, "_hold_ready"}, ready_out, 0);
    end
    ready_in = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_after"}, ready_out, 1);
    chk({tag, "_valid_after"}, valid_out, 0);
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] a, b, mq, mr;
    logic         mz, seen;

`ifdef DIV_SIGNED_EN
    vecs[0] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, W+2};
    vecs[1] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, W+2};
    vecs[2] = '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, W+2};
    vecs[3] = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 2};
    vecs[4] = '{8'd100, 8'd7, 8'd14, 8'd2, 1'b0, W+2};
    vecs[5] = '{8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 2};
    vecs[6] = '{8'h81, 8'h7F, 8'hFF, 8'h00, 1'b0, W+2};
`else
    vecs[0] = '{8'd100, 8'd7, 8'd14, 8'd2, 1'b0, W+2};
    vecs[1] = '{8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 2};
    vecs[2] = '{8'd0, 8'd5, 8'd0, 8'd0, 1'b0, W+2};
    vecs[3] = '{8'd7, 8'd255, 8'd0, 8'd7, 1'b0, W+2};
    vecs[4] = '{8'd255, 8'd255, 8'd1, 8'd0, 1'b0, W+2};
    vecs[5] = '{8'd200, 8'd16, 8'd12, 8'd8, 1'b0, W+2};
    vecs[6] = '{8'd254, 8'd1, 8'd254, 8'd0, 1'b0, W+2};
`endif

    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready_out, 1);
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, 0, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat,
             $sformatf("vec%0d", i));

    // Back-pressure: result held stable for 20 stalled cycles.
    run_op(8'd255, 8'd1, 20, 8'd255, 8'd0, 1'b0, W+2, "stall");

    // Flush on the third RUN cycle: no result, then a clean follow-up op.
    dividend = 8'd200; divisor = 8'd3; valid_in = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_busy_before", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_ready", ready_out, 1);
    seen = valid_out;
    repeat (12) begin @(negedge clk); seen |= valid_out; end
    chk("flush_no_valid", seen, 0);
    run_op(8'd9, 8'd4, 0, 8'd2, 8'd1, 1'b0, W+2, "after_flush");

    // Handshake attempted while flushing is ignored.
    dividend = 8'd9; divisor = 8'd4; valid_in = 1'b1; flush = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", busy, 0);
    @(negedge clk);
    chk("flush_idle_valid", valid_out, 0);

    // Asynchronous reset in the middle of RUN.
    dividend = 8'd77; divisor = 8'd3; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", valid_out, 0);
    chk("arst_ready", ready_out, 1);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random operations with random back-pressure.
    for (int n = 0; n < 200; n++) begin
      a = W'($urandom);
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 3));
        2: begin a = 8'h80; b = 8'hFF; end
        default: b = W'($urandom);
      endcase
      model(a, b, mq, mr, mz);
      run_op(a, b, $urandom_range(0, 3), mq, mr, mz, (b == 0) ? 2 : W + 2,
             $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
